// File: rtl/sync_fifo_flagged_if.sv
// Handshake bundle between a producer/consumer and sync_fifo_flagged.
// The master side (host or SDRAM controller) drives requests, the slave
// side (the FIFO) returns data, occupancy and status flags.
interface sync_fifo_flagged_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic             Flush;
   logic             WriteEn;
   logic [WIDTH-1:0] WriteData;
   logic             ReadEn;
   logic [WIDTH-1:0] ReadData;
   logic             ReadValid;
   logic             FifoFullSign;
   logic             FifoEmptySign;
   logic             AlmostFull;
   logic             AlmostEmpty;
   logic [AW:0]      Count;
   logic             Overflow;
   logic             Underflow;

   modport master (
      output Flush, WriteEn, WriteData, ReadEn,
      input  ReadData, ReadValid, FifoFullSign, FifoEmptySign,
             AlmostFull, AlmostEmpty, Count, Overflow, Underflow
   );

   modport slave (
      input  Flush, WriteEn, WriteData, ReadEn,
      output ReadData, ReadValid, FifoFullSign, FifoEmptySign,
             AlmostFull, AlmostEmpty, Count, Overflow, Underflow
   );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty flags, sticky overflow/underflow, synchronous flush and
// a choice of first-word-fall-through or registered read.
// Pointers carry one extra wrap bit; memory is indexed by the low bits.
module sync_fifo_flagged #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 4,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 1
) (
   input logic                 Clk,
   input logic                 Rest,
   sync_fifo_flagged_if.slave  Bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0] ZeroCnt  = {(AW+1){1'b0}};
   localparam logic [AW:0] OneCnt   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
   localparam logic [AW:0] AfullTh  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0] AemptyTh = (AW+1)'(AEMPTY_TH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      writePtr;
   logic [AW:0]      readPtr;
   logic [AW:0]      count;
   logic [AW:0]      countNext;
   logic             fullR;
   logic             emptyR;
   logic             afullR;
   logic             aemptyR;
   logic             overflowR;
   logic             underflowR;
   logic             wrAcc;
   logic             rdAcc;

   // Accept decisions use the registered flags, i.e. the state before the edge.
   assign wrAcc = Bus.WriteEn & ~fullR  & ~Bus.Flush;
   assign rdAcc = Bus.ReadEn  & ~emptyR & ~Bus.Flush;

   // Next occupancy; reset and flush both empty the FIFO.
   always_comb begin
      countNext = count;
      if (Rest || Bus.Flush) begin
         countNext = ZeroCnt;
      end else begin
         case ({wrAcc, rdAcc})
            2'b10:   countNext = count + OneCnt;
            2'b01:   countNext = count - OneCnt;
            default: countNext = count;
         endcase
      end
   end

   // Count and level flags, all derived from the next count so they agree.
   always_ff @(posedge Clk) begin
      count   <= countNext;
      fullR   <= (countNext == DepthCnt);
      emptyR  <= (countNext == ZeroCnt);
      afullR  <= (countNext >= AfullTh);
      aemptyR <= (countNext <= AemptyTh);
   end

   // Read and write pointers, advanced only on accepted transfers.
   always_ff @(posedge Clk) begin
      if (Rest || Bus.Flush) begin
         writePtr <= ZeroCnt;
         readPtr  <= ZeroCnt;
      end else begin
         if (wrAcc) begin
            writePtr <= writePtr + OneCnt;
         end
         if (rdAcc) begin
            readPtr <= readPtr + OneCnt;
         end
      end
   end

   // Sticky error flags, cleared only by reset or flush.
   always_ff @(posedge Clk) begin
      if (Rest || Bus.Flush) begin
         overflowR  <= 1'b0;
         underflowR <= 1'b0;
      end else begin
         if (Bus.WriteEn && fullR) begin
            overflowR <= 1'b1;
         end
         if (Bus.ReadEn && emptyR) begin
            underflowR <= 1'b1;
         end
      end
   end

   // Storage array; only accepted writes touch it, and it is never cleared.
   always_ff @(posedge Clk) begin
      if (wrAcc && !Rest) begin
         mem[writePtr[AW-1:0]] <= Bus.WriteData;
      end
   end

   generate
      if (FWFT != 0) begin : gFwft
         // Head entry is shown directly; valid whenever the FIFO holds data.
         assign Bus.ReadData  = mem[readPtr[AW-1:0]];
         assign Bus.ReadValid = ~emptyR;
      end else begin : gRegRead
         logic [WIDTH-1:0] readDataR;
         logic             readValidR;

         // Registered read: data lands one cycle after an accepted pop.
         always_ff @(posedge Clk) begin
            if (Rest) begin
               readDataR  <= {WIDTH{1'b0}};
               readValidR <= 1'b0;
            end else if (Bus.Flush) begin
               readValidR <= 1'b0;
            end else if (rdAcc) begin
               readDataR  <= mem[readPtr[AW-1:0]];
               readValidR <= 1'b1;
            end else begin
               readValidR <= 1'b0;
            end
         end

         assign Bus.ReadData  = readDataR;
         assign Bus.ReadValid = readValidR;
      end
   endgenerate

   assign Bus.Count         = count;
   assign Bus.FifoFullSign  = fullR;
   assign Bus.FifoEmptySign = emptyR;
   assign Bus.AlmostFull    = afullR;
   assign Bus.AlmostEmpty   = aemptyR;
   assign Bus.Overflow      = overflowR;
   assign Bus.Underflow     = underflowR;
endmodule

// File: doc/sync_fifo_flagged.md
Name: sync_fifo_flagged

Overview:
Parametrised single-clock FIFO, the next generation of the existing SDRAM-controller FIFO. It adds:
- arbitrary power-of-2 depth, with an occupancy count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a synchronous flush;
- selectable read mode: first-word-fall-through (FWFT) or registered read.

It sits between the host command/data path and the SDRAM controller, as a command queue and as read/write data buffers.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 16: number of entries. Must be a power of 2, 2..1024. AW = $clog2(DEPTH).
- AFULL_TH, DEPTH-4: AlmostFull asserts when Count >= AFULL_TH. Legal range 1..DEPTH.
- AEMPTY_TH, 2: AlmostEmpty asserts when Count <= AEMPTY_TH. Legal range 0..DEPTH-1.
- FWFT, 1: 1 = head entry visible on ReadData without a read; 0 = registered read, one cycle latency.

Ports:
- Clk  in  1  single clock; all logic on posedge.
- Rest  in  1  reset, synchronous, active-high.
- Flush  in  1  synchronous clear of contents and error flags.
- WriteEn  in  1  write request.
- WriteData  in  WIDTH  write data.
- ReadEn  in  1  read request (pop).
- ReadData  out  WIDTH  read data.
- ReadValid  out  1  ReadData holds valid data.
- FifoFullSign  out  1  Count == DEPTH.
- FifoEmptySign  out  1  Count == 0.
- AlmostFull  out  1  Count >= AFULL_TH.
- AlmostEmpty  out  1  Count <= AEMPTY_TH.
- Count  out  AW+1  current occupancy, 0..DEPTH.
- Overflow  out  1  sticky: a write was attempted while full.
- Underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Pointers:
  - WritePtr and ReadPtr are AW+1 bits wide, with the MSB as the wrap bit.
  - Memory is indexed by [AW-1:0].
  - Pointers wrap naturally modulo 2*DEPTH.
- Accept rules, evaluated on the state before the clock edge:
  - wr_acc = WriteEn & ~FifoFullSign & ~Flush.
  - rd_acc = ReadEn & ~FifoEmptySign & ~Flush.
  - Memory is written only on wr_acc. A rejected write must never corrupt an entry.
- Count update:
  - wr_acc only: Count + 1.
  - rd_acc only: Count - 1.
  - both, or neither: Count unchanged.
  - A write when full is rejected even if a read is in the same cycle. The read still proceeds.
- Flags: FifoFullSign, FifoEmptySign, AlmostFull and AlmostEmpty are registered. Each is computed from the next-state Count, so all flags agree with Count in the same cycle.
- Error flags:
  - Overflow sets on WriteEn & FifoFullSign & ~Flush.
  - Underflow sets on ReadEn & FifoEmptySign & ~Flush.
  - Both stay set until Rest or Flush.
- Flush:
  - Pointers and Count go to 0, FifoEmptySign to 1, Overflow and Underflow to 0.
  - WriteEn and ReadEn in the same cycle are ignored.
  - Memory contents are not cleared.
  - In FWFT=0 mode, ReadValid goes to 0.
- Rest:
  - Has priority over Flush.
  - Gives the same result as Flush.
  - Also sets ReadData to 0 when FWFT=0.
  - Reset during any operation discards all contents. The FIFO is empty on the next cycle.
- Reset values:
  - FifoEmptySign = 1.
  - AlmostEmpty = 1.
  - FifoFullSign = 0, AlmostFull = 0, Count = 0.
  - Overflow = 0, Underflow = 0, ReadValid = 0.
  - ReadData = 0 when FWFT=0.
- FWFT=1:
  - ReadData = Mem[ReadPtr] combinationally.
  - ReadValid = ~FifoEmptySign.
  - A write into an empty FIFO is visible on ReadData on the cycle after the write edge.
  - ReadEn pops the entry currently shown.
- FWFT=0:
  - On rd_acc, ReadData is loaded with Mem[ReadPtr] at the edge. ReadValid is 1 for exactly the next cycle.
  - Otherwise ReadData holds its value and ReadValid is 0.
  - Latency is 1 cycle from ReadEn to data.
- Simultaneous read and write on an empty FIFO: only the write is accepted. Underflow is set if ReadEn was high.

Test Plan:
1. Fill (DEPTH=16, FWFT=1): reset, then 16 writes 0x00..0x0F with no reads.
   -> AlmostFull rises when Count reaches 12; FifoFullSign=1 at Count=16.
   -> A 17th write (0xAA) sets Overflow and leaves the entries unchanged.
   -> 16 reads return 0x00..0x0F in order; FifoEmptySign=1 and AlmostEmpty=1 at the end.
2. Wrap-around: 40 iterations of write, write, read, read with incrementing data.
   -> Pointers wrap at least twice.
   -> Read data are strictly sequential.
   -> Count oscillates between 0 and 2.
3. Simultaneous read and write:
   - At Count=16, assert WriteEn and ReadEn together -> Count=15, write rejected, Overflow=1.
   - At Count=5 -> Count stays 5, data order preserved.
4. Underflow and Flush:
   - ReadEn while empty -> Underflow=1, Count=0.
   - Write 3 entries, then Flush with WriteEn high -> Count=0, FifoEmptySign=1, Overflow=0, Underflow=0, write ignored.
5. Registered read (FWFT=0): write 0x11 and 0x22, then ReadEn for 2 cycles.
   -> ReadValid=1 and ReadData=0x11 on the cycle after the first edge, then 0x22.
   -> ReadValid=0 afterwards, with ReadData holding 0x22.
6. Reset mid-operation: Rest high for 1 cycle at Count=9, with WriteEn high.
   -> The next cycle shows Count=0, FifoEmptySign=1 and all flags at their reset values.
   -> The first write after reset is read back correctly.
